// File: rtl/uart_receiver.sv
// uart_receiver -- 8N1 serial-to-parallel UART receiver.
//
// Samples an asynchronous idle-high line (1 start bit, 8 data bits LSB
// first, 1 stop bit). Each good byte is presented on `data` with a
// one-cycle `valid` strobe; a stop bit sampled low raises a one-cycle
// `frame_err` and the receiver then waits for the line to return high.
//
// Parameters:
//   clock     system clock frequency in Hz
//   baudrate  line rate in bit/s; T = clock/baudrate must be >= 4
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, asynchronous to clk, idle high
//   data       out  [7:0] last good byte, held until the next good frame
//   valid      out  one-cycle pulse when data has just been updated
//   frame_err  out  one-cycle pulse when the stop bit was sampled low
//   busy       out  high whenever the receiver is not idle
//
// Build option:
//   UART_RECEIVER_MAJORITY_EN  when defined, edge detection and sampling
//   use a 3-sample majority vote of the synchronised line, rejecting
//   single-cycle glitches at the cost of one extra cycle of latency.

module uart_receiver #(
  parameter int clock    = 50_000_000,
  parameter int baudrate = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned T = clock / baudrate;
  localparam int unsigned H = T / 2;
  localparam logic [31:0] T_M1 = 32'(T - 1);
  localparam logic [31:0] H_M1 = 32'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Two-flop synchroniser; idles at 1 so reset never looks like a start bit.
  logic sync1_q, sync2_q;
  logic rxs;
  logic rx_use;

  assign rxs = sync2_q;

`ifdef UART_RECEIVER_MAJORITY_EN
  // The two previous samples plus the current rxs form the 3-bit history.
  logic [1:0] hist_q;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  assign rx_use = maj3({hist_q, rxs});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxs};
    end
  end
`else
  assign rx_use = rxs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  state_t      state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        sample;

  assign sample = (wait_q == 32'd0);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    // The bit-period counter only runs while a frame is in progress.
    if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
      wait_d = sample ? T_M1 : (wait_q - 32'd1);
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_use) begin
          state_d = S_START;
          // First sample lands mid start bit.
          wait_d  = H_M1;
        end
      end
      S_START: begin
        if (sample) begin
          if (!rx_use) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          // LSB arrives first, so after 8 shifts it sits in bit 0.
          shift_d   = {rx_use, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (sample) begin
          if (rx_use) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line is released so a stuck-low line is not
        // decoded as a stream of 0x00 frames.
        if (rx_use) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 32'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver with T=16, H=8. Stimulus pushes the expected
// pulse (kind, data, cycle) into a queue; a monitor pops and compares on
// every valid/frame_err pulse.

module tb_uart_receiver;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(
    .clock    (16),
    .baudrate (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Pulse appears 2 (synchroniser) + H + 9*T + 1 cycles after the pin falls.
`ifdef UART_RECEIVER_MAJORITY_EN
  localparam longint LAT = 156;
`else
  localparam longint LAT = 155;
`endif

  typedef struct {
    bit         err;
    logic [7:0] d;
    longint     c;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  longint     cyc = 0;
  logic [7:0] last_good = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      if (q.size() == 0) begin
        chk("spurious_pulse", longint'({valid, frame_err}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", longint'({valid, frame_err}), e.err ? 1 : 2);
        chk("pulse_data", longint'(data), longint'(e.d));
        chk("pulse_cycle", cyc, e.c);
      end
    end
  end

  // Called right at a rising edge; drives a full frame at r cycles/bit.
  task automatic send_frame(input logic [7:0] b, input int r, input bit stop_v,
                            input bit glitch);
    exp_t   e;
    longint fall;
    #1;
    fall = cyc;
    rx = 1'b0;
    e.err = !stop_v;
    e.d   = stop_v ? b : last_good;
    e.c   = fall + LAT;
    q.push_back(e);
    if (stop_v) last_good = b;
    repeat (r) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      if (glitch) begin
        // One-cycle inversion at the bit centre.
        repeat (7) @(posedge clk);
        #1 rx = ~b[i];
        @(posedge clk);
        #1 rx = b[i];
        repeat (r - 8) @(posedge clk);
      end else begin
        repeat (r) @(posedge clk);
      end
    end
    #1 rx = stop_v;
    repeat (r) @(posedge clk);
  endtask

  task automatic idle(input int k);
    #1 rx = 1'b1;
    repeat (k) @(posedge clk);
  endtask

  task automatic wait_cyc(input longint t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint n;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_data", longint'(data), 0);
    chk("reset_valid", longint'(valid), 0);
    chk("reset_frame_err", longint'(frame_err), 0);
    chk("reset_busy", longint'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single byte
    send_frame(8'hA5, 16, 1'b1, 1'b0);
    idle(40);

    // Back-to-back, no idle gap: pulses 160 cycles apart
    send_frame(8'h00, 16, 1'b1, 1'b0);
    send_frame(8'hFF, 16, 1'b1, 1'b0);
    send_frame(8'h5A, 16, 1'b1, 1'b0);
    idle(40);

    // Start glitch: 3 low cycles, then a real frame
    #1 n = cyc;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    wait_cyc(n + 2 + 5);
    chk("glitch_busy_high", longint'(busy), 1);
    wait_cyc(n + 2 + 12);
    chk("glitch_busy_low", longint'(busy), 0);
    @(posedge clk);
    idle(20);
    send_frame(8'h3C, 16, 1'b1, 1'b0);
    idle(40);

    // Framing error then held-low line
    #1 n = cyc;
    @(posedge clk);
    send_frame(8'h81, 16, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #2;
    chk("break_busy", longint'(busy), 1);
    chk("break_data_held", longint'(data), 8'h3C);
    @(posedge clk);
    idle(30);
    #2;
    chk("break_released_busy", longint'(busy), 0);
    @(posedge clk);
    send_frame(8'h42, 16, 1'b1, 1'b0);
    idle(40);

    // Reset in the middle of data bit 4 of 0x77
    #1 rx = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx = (8'h77 >> i) & 8'h01;
      repeat (16) @(posedge clk);
    end
    #1 rx = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_data", longint'(data), 0);
    chk("midreset_valid", longint'(valid), 0);
    chk("midreset_frame_err", longint'(frame_err), 0);
    chk("midreset_busy", longint'(busy), 0);
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(200);
    chk("after_reset_busy", longint'(busy), 0);
    send_frame(8'h11, 16, 1'b1, 1'b0);
    idle(40);

    // Baud tolerance. A 1-cycle/bit error drifts by almost 10 cycles over
    // the frame, so the bytes keep the bits near the drifted sample points
    // (bits 5..7 for the fast line, bit 7 for the slow one) at 1.
    send_frame(8'hE3, 15, 1'b1, 1'b0);
    idle(40);
    send_frame(8'h96, 17, 1'b1, 1'b0);
    idle(40);

`ifdef UART_RECEIVER_MAJORITY_EN
    send_frame(8'hA5, 16, 1'b1, 1'b1);
    idle(40);
    send_frame(8'h3C, 16, 1'b1, 1'b1);
    idle(40);
`endif

    idle(200);
    chk("all_pulses_seen", longint'(q.size()), 0);
    chk("final_data", longint'(data), longint'(last_good));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
